// File: rtl/stage0_block_loader_if.sv
// Byte-stream / block handshake bundle between a stream source, the block
// loader and the Stage1 consumer. Clock and reset stay outside the bundle.
interface stage0_block_loader_if #(
  parameter int unsigned KEY_W = 10
);
  logic [KEY_W-1:0] key;
  logic             key_load;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic [127:0]     blk;
  logic             Enable;
  logic             k9;
  logic             k8;
  logic             out_ready;
  logic             short_blk;

  // Source / consumer side: drives the stream, key and acknowledge.
  modport master (
    output key, key_load, in_valid, in_data, in_last, out_ready,
    input  in_ready, blk, Enable, k9, k8, short_blk
  );

  // Loader side.
  modport slave (
    input  key, key_load, in_valid, in_data, in_last, out_ready,
    output in_ready, blk, Enable, k9, k8, short_blk
  );
endinterface

// File: rtl/stage0_block_loader.sv
// Collects a serial byte stream into one 16-byte block (a0 first, d3 last),
// captures the two mode bits from the round key and holds block + mode for a
// combinational Stage1 until downstream acknowledges with out_ready.
module stage0_block_loader #(
  parameter int unsigned KEY_W = 10,
  parameter logic [7:0]  PAD   = 8'h00
) (
  input logic                  clk,
  input logic                  rst_n,
  stage0_block_loader_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [127:0]     blk_q, blk_d;
  logic [1:0]       mode_q, mode_d;
  logic             short_q, short_d;
  logic             enable_q, enable_d;
  logic             in_ready_q, in_ready_d;

  logic             accept;
  logic             complete;
  logic [1:0]       mode_src;

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    key_d    = key_q;
    blk_d    = blk_q;
    mode_d   = mode_q;
    short_d  = short_q;
    complete = 1'b0;
    accept   = bus.in_valid && in_ready_q && (state_q == FILL);

    // A key loaded in the completing cycle bypasses the key register.
    mode_src = bus.key_load ? bus.key[KEY_W-1 -: 2] : key_q[KEY_W-1 -: 2];

    if (bus.key_load) begin
      key_d = bus.key;
    end

    case (state_q)
      IDLE: begin
        if (bus.key_load) begin
          state_d = FILL;
        end
      end

      FILL: begin
        if (accept) begin
          blk_d[int'(cnt_q)*8 +: 8] = bus.in_data;
          cnt_d = cnt_q + 4'd1;
          if (cnt_q == 4'hF) begin
            complete = 1'b1;
          end else if (bus.in_last) begin
            for (int unsigned i = 0; i < 16; i++) begin
              if (i > 32'(cnt_q)) begin
                blk_d[i*8 +: 8] = PAD;
              end
            end
            short_d  = 1'b1;
            cnt_d    = '0;
            complete = 1'b1;
          end
          if (complete) begin
            state_d = HOLD;
            mode_d  = mode_src;
          end
        end
      end

      HOLD: begin
        if (bus.out_ready) begin
          // A short block ends the message; the next one needs a fresh key.
          state_d = short_q ? IDLE : FILL;
          short_d = 1'b0;
          blk_d   = '0;
          mode_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        blk_d   = '0;
        mode_d  = '0;
        short_d = 1'b0;
      end
    endcase

    // Handshake outputs are registered copies of the next-state decode, so
    // nothing from in_* or out_ready reaches an output combinationally.
    enable_d   = (state_d == HOLD);
    in_ready_d = (state_d == FILL);
  end

  // State and output registers; reset drops Enable immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      key_q      <= '0;
      blk_q      <= '0;
      mode_q     <= '0;
      short_q    <= 1'b0;
      enable_q   <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      key_q      <= key_d;
      blk_q      <= blk_d;
      mode_q     <= mode_d;
      short_q    <= short_d;
      enable_q   <= enable_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.Enable    = enable_q;
  assign bus.blk       = enable_q ? blk_q : '0;
  assign bus.k9        = enable_q & mode_q[1];
  assign bus.k8        = enable_q & mode_q[0];
  assign bus.short_blk = short_q;

endmodule

// File: tb/tb_stage0_block_loader.sv
// Directed and randomised-handshake checks for stage0_block_loader.
module tb_stage0_block_loader;

  logic clk;
  logic rst_n;

  stage0_block_loader_if #(.KEY_W(10)) bus ();

  stage0_block_loader #(.KEY_W(10), .PAD(8'h00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last);
    int unsigned w;
    w = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    while (!bus.in_ready && w < 40) begin
      tick();
      w++;
    end
    if (!bus.in_ready) check_eq("in_ready_timeout", 128'(bus.in_ready), 128'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic load_key(input logic [9:0] k);
    bus.key      = k;
    bus.key_load = 1'b1;
    tick();
    bus.key_load = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] exp_blk;
    int unsigned  seq, acc, blocks, cyc;
    logic         acc_now, prev_en;

    rst_n         = 1'b0;
    bus.key       = '0;
    bus.key_load  = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    check_eq("rst_enable",   128'(bus.Enable),    128'd0);
    check_eq("rst_in_ready", 128'(bus.in_ready),  128'd0);
    check_eq("rst_blk",      bus.blk,             128'd0);
    check_eq("rst_short",    128'(bus.short_blk), 128'd0);
    rst_n = 1'b1;
    tick();
    check_eq("idle_in_ready", 128'(bus.in_ready), 128'd0);

    // Full block 00..0F, key 300, out_ready always high
    load_key(10'h300);
    check_eq("fill_in_ready", 128'(bus.in_ready), 128'd1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check_eq("t1_no_enable_mid", 128'(bus.Enable), 128'd0);
      send_byte(8'(i), 1'b0);
    end
    check_eq("t1_enable",   128'(bus.Enable),    128'd1);
    check_eq("t1_blk",      bus.blk,             128'h0F0E0D0C0B0A09080706050403020100);
    check_eq("t1_k9",       128'(bus.k9),        128'd1);
    check_eq("t1_k8",       128'(bus.k8),        128'd1);
    check_eq("t1_short",    128'(bus.short_blk), 128'd0);
    check_eq("t1_in_ready", 128'(bus.in_ready),  128'd0);
    tick();
    check_eq("t1_enable_1cyc", 128'(bus.Enable),   128'd0);
    check_eq("t1_blk_gated",   bus.blk,            128'd0);
    check_eq("t1_back_fill",   128'(bus.in_ready), 128'd1);

    // Key 100 loaded mid-FILL, 16 x A5, out_ready low 5 cycles
    bus.out_ready = 1'b0;
    load_key(10'h100);
    for (int i = 0; i < 16; i++) send_byte(8'hA5, 1'b0);
    for (int i = 0; i < 5; i++) begin
      check_eq("t2_enable",   128'(bus.Enable),   128'd1);
      check_eq("t2_blk",      bus.blk,            {16{8'hA5}});
      check_eq("t2_in_ready", 128'(bus.in_ready), 128'd0);
      check_eq("t2_k9",       128'(bus.k9),       128'd0);
      check_eq("t2_k8",       128'(bus.k8),       128'd1);
      tick();
    end
    bus.out_ready = 1'b1;
    tick();
    check_eq("t2_release_en", 128'(bus.Enable),   128'd0);
    check_eq("t2_release_rdy", 128'(bus.in_ready), 128'd1);
    bus.out_ready = 1'b0;

    // Short block 11,22,33 with in_last on the third
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b1);
    check_eq("t3_enable", 128'(bus.Enable),    128'd1);
    check_eq("t3_blk",    bus.blk,             128'h00000000000000000000000000332211);
    check_eq("t3_short",  128'(bus.short_blk), 128'd1);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("t3_short_clr", 128'(bus.short_blk), 128'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    for (int i = 0; i < 3; i++) begin
      check_eq("t3_idle_in_ready", 128'(bus.in_ready), 128'd0);
      check_eq("t3_idle_enable",   128'(bus.Enable),   128'd0);
      tick();
    end
    bus.in_valid = 1'b0;

    // Key 200 loaded with the 16th byte, previous key 000
    load_key(10'h000);
    for (int i = 0; i < 15; i++) send_byte(8'h10 + 8'(i), 1'b0);
    bus.key      = 10'h200;
    bus.key_load = 1'b1;
    send_byte(8'h1F, 1'b1);
    bus.key_load = 1'b0;
    check_eq("t4_k9",    128'(bus.k9),        128'd1);
    check_eq("t4_k8",    128'(bus.k8),        128'd0);
    check_eq("t4_blk",   bus.blk,             128'h1F1E1D1C1B1A19181716151413121110);
    check_eq("t4_short", 128'(bus.short_blk), 128'd0);
    load_key(10'h000);
    check_eq("t4_hold_k9", 128'(bus.k9), 128'd1);
    check_eq("t4_hold_k8", 128'(bus.k8), 128'd0);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    check_eq("t4_back_fill", 128'(bus.in_ready), 128'd1);

    // Reset after 9 bytes, then a clean all-FF block
    for (int i = 0; i < 9; i++) send_byte(8'hC0 + 8'(i), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_rst_enable",   128'(bus.Enable),   128'd0);
    check_eq("t5_rst_in_ready", 128'(bus.in_ready), 128'd0);
    tick();
    check_eq("t5_rst_enable2", 128'(bus.Enable), 128'd0);
    rst_n = 1'b1;
    tick();
    load_key(10'h000);
    for (int i = 0; i < 16; i++) send_byte(8'hFF, 1'b0);
    check_eq("t5_enable", 128'(bus.Enable), 128'd1);
    check_eq("t5_blk",    bus.blk,          {128{1'b1}});

    // Reset while holding drops Enable without a clock edge
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_hold_rst_enable", 128'(bus.Enable), 128'd0);
    check_eq("t5_hold_rst_blk",    bus.blk,          128'd0);
    tick();
    rst_n = 1'b1;
    tick();
    load_key(10'h0C0);

    // Random in_valid / out_ready over 100 full blocks
    seq     = 0;
    acc     = 0;
    blocks  = 0;
    cyc     = 0;
    prev_en = 1'b0;
    exp_blk = '0;
    bus.in_last = 1'b0;
    while (blocks < 100 && cyc < 20000) begin
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.in_data   = seq[7:0];
      bus.out_ready = ($urandom_range(0, 3) == 0);
      acc_now = bus.in_valid && bus.in_ready;
      tick();
      cyc++;
      if (acc_now) begin
        exp_blk[(acc % 16)*8 +: 8] = seq[7:0];
        seq++;
        acc++;
      end
      if (bus.Enable && !prev_en) begin
        check_eq("rand_blk", bus.blk, exp_blk);
        check_eq("rand_cnt_at_enable", 128'(acc % 16), 128'd0);
        blocks++;
      end
      prev_en = bus.Enable;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("rand_blocks_done", 128'(blocks), 128'd100);
    check_eq("rand_bytes",       128'(acc),    128'd1600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
